// File: rtl/rb_window_reader_pkg.sv
// rb_window_reader_pkg
// Shared definitions for the row-buffer window reader:
//   - default geometry (pixel width, image size, window size, ring depth)
//   - FSM state encoding (3 bits)
//   - clog2_min1: width helper that never returns 0
package rb_window_reader_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;
  localparam int K_DEF      = 3;
  localparam int NUM_RB_DEF = 4;
  localparam int RD_AW_DEF  = $clog2(NUM_RB_DEF * IMG_W_DEF);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Counter/index width that stays at least 1 bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rb_window_reader_shift.sv
// rb_window_reader_shift
// Column assembly and KxK window shift array.
//   clk, rst   : clock, synchronous active-high reset (clears everything)
//   cap_en     : cap_data is the pixel for row cap_slot of the current column
//   cap_slot   : row index (0 = top) of the pixel on cap_data
//   cap_data   : pixel from BRAM read port
//   shift_en   : shift window one column left, new column enters c=K-1
//   win_data   : packed window, pixel (r,c) at [(r*K+c)*DATA_W +: DATA_W]
module rb_window_reader_shift
  import rb_window_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  parameter int RR_W   = clog2_min1(K_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic [RR_W-1:0]       cap_slot,
  input  logic [DATA_W-1:0]     cap_data,
  input  logic                  shift_en,
  output logic [K*K*DATA_W-1:0] win_data
);

  logic [DATA_W-1:0] stage  [K];
  logic [DATA_W-1:0] col_in [K];
  logic [DATA_W-1:0] win    [K][K];

  // The bottom pixel arrives in the same cycle as the shift, so it bypasses
  // its stage register and goes straight into the window.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col_in[r] = (cap_en && cap_slot == RR_W'(r)) ? cap_data : stage[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        stage[r] <= '0;
        for (int c = 0; c < K; c++) win[r][c] <= '0;
      end
    end else begin
      for (int r = 0; r < K; r++) begin
        if (cap_en && cap_slot == RR_W'(r)) stage[r] <= cap_data;
      end
      if (shift_en) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= col_in[r];
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) win_data[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
    end
  end

endmodule

// File: rtl/rb_window_reader.sv
// rb_window_reader
// Read side of the BRAM row-buffer ring: waits for K committed rows, reads
// them column by column through port B, builds KxK windows and hands them to
// the NIP kernel. The oldest row buffer is released after each output row.
// Optional macro RB_WIN_COORD_EN adds win_x / win_y window coordinates.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : frame start pulse (ignored while busy)
//   wr_row_done     : writer committed one row to the next ring slot
//   rd_en, rd_addr  : BRAM port-B read; rd_data valid one cycle after rd_en
//   win_valid/ready : window handshake. A window transfers on a clock edge
//                     where win_valid && win_ready; win_data is held
//                     stable while win_valid is high and not yet accepted;
//                     win_ready while win_valid is low has no effect.
//   win_data        : KxK window, (r,c) at [(r*K+c)*DATA_W +: DATA_W]
//   rb_release      : one-cycle pulse, oldest row buffer freed
//   busy, complete  : frame in progress / frame finished (S_DONE)
//   ovf_err         : sticky, row committed while ring already full
//   win_x, win_y    : (RB_WIN_COORD_EN) left column / top row of window
//   dbg_state       : current FSM state
//   dbg_rows_avail  : committed rows not yet released
module rb_window_reader
  import rb_window_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int NUM_RB = NUM_RB_DEF,
  parameter int RD_AW  = $clog2(NUM_RB * IMG_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          wr_row_done,
  output logic                          rd_en,
  output logic [RD_AW-1:0]              rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [K*K*DATA_W-1:0]         win_data,
  output logic                          rb_release,
  output logic                          busy,
  output logic                          complete,
  output logic                          ovf_err,
`ifdef RB_WIN_COORD_EN
  output logic [clog2_min1(IMG_W)-1:0]  win_x,
  output logic [clog2_min1(IMG_H)-1:0]  win_y,
`endif
  output state_t                        dbg_state,
  output logic [$clog2(NUM_RB+1)-1:0]   dbg_rows_avail
);

  localparam int COL_W = clog2_min1(IMG_W);
  localparam int ROW_W = clog2_min1(IMG_H + 1);
  localparam int RB_W  = clog2_min1(NUM_RB);
  localparam int RR_W  = clog2_min1(K);
  localparam int CNT_W = $clog2(NUM_RB + 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] out_row;
  logic [RB_W-1:0]  top_rb;
  logic [RB_W-1:0]  rd_slot;
  logic [RR_W-1:0]  rd_r;
  logic             rows_ok;
  logic [CNT_W-1:0] rows_avail;
  logic [CNT_W-1:0] rows_avail_nxt;
  logic             cap_en;
  logic [RR_W-1:0]  cap_slot;

  function automatic logic [RB_W-1:0] rb_inc(input logic [RB_W-1:0] s);
    return (s == RB_W'(NUM_RB - 1)) ? '0 : s + 1'b1;
  endfunction

  // Committed-row counter; runs in every state.
  always_comb begin
    rows_avail_nxt = rows_avail;
    if (wr_row_done && !rb_release) begin
      if (rows_avail != CNT_W'(NUM_RB)) rows_avail_nxt = rows_avail + 1'b1;
    end else if (!wr_row_done && rb_release) begin
      if (rows_avail != '0) rows_avail_nxt = rows_avail - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_avail <= '0;
      ovf_err    <= 1'b0;
    end else begin
      rows_avail <= rows_avail_nxt;
      if (wr_row_done && !rb_release && rows_avail == CNT_W'(NUM_RB)) ovf_err <= 1'b1;
    end
  end

  // rows_ok is a registered "enough rows" flag. It is cleared on every entry
  // to S_WAIT so the decision never uses a count that predates a pending
  // release; the first look at the count is therefore one cycle after entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      out_row    <= '0;
      top_rb     <= '0;
      rd_slot    <= '0;
      rd_r       <= '0;
      rows_ok    <= 1'b0;
      rb_release <= 1'b0;
    end else begin
      rb_release <= 1'b0;
      rows_ok    <= (rows_avail_nxt >= CNT_W'(K));
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_WAIT;
            top_rb  <= '0;
            col     <= '0;
            out_row <= '0;
            rows_ok <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rows_ok) begin
            state   <= S_RD;
            rd_r    <= '0;
            rd_slot <= top_rb;
          end
        end
        S_RD: begin
          rd_slot <= rb_inc(rd_slot);
          if (rd_r == RR_W'(K - 1)) state <= S_CAP;
          else                      rd_r  <= rd_r + 1'b1;
        end
        S_CAP: begin
          if (col < COL_W'(K - 1)) begin
            col     <= col + 1'b1;
            state   <= S_RD;
            rd_r    <= '0;
            rd_slot <= top_rb;
          end else begin
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (win_ready) begin
            if (col != COL_W'(IMG_W - 1)) begin
              col     <= col + 1'b1;
              state   <= S_RD;
              rd_r    <= '0;
              rd_slot <= top_rb;
            end else begin
              rb_release <= 1'b1;
              top_rb     <= rb_inc(top_rb);
              col        <= '0;
              out_row    <= out_row + 1'b1;
              rows_ok    <= 1'b0;
              if (out_row + 1'b1 == ROW_W'(IMG_H - K + 1)) state <= S_DONE;
              else                                         state <= S_WAIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after rd_en; tag it with its row slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_en   <= 1'b0;
      cap_slot <= '0;
    end else begin
      cap_en   <= (state == S_RD);
      cap_slot <= rd_r;
    end
  end

  assign rd_en          = (state == S_RD);
  assign rd_addr        = RD_AW'(int'(rd_slot) * IMG_W + int'(col));
  assign win_valid      = (state == S_OUT);
  assign busy           = (state == S_WAIT) || (state == S_RD) ||
                          (state == S_CAP)  || (state == S_OUT);
  assign complete       = (state == S_DONE);
  assign dbg_state      = state;
  assign dbg_rows_avail = rows_avail;

  rb_window_reader_shift #(
    .DATA_W (DATA_W),
    .K      (K),
    .RR_W   (RR_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_slot (cap_slot),
    .cap_data (rd_data),
    .shift_en (state == S_CAP),
    .win_data (win_data)
  );

`ifdef RB_WIN_COORD_EN
  // Coordinates latch when a finished window is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_x <= '0;
      win_y <= '0;
    end else if (state == S_CAP && !(col < COL_W'(K - 1))) begin
      win_x <= col - COL_W'(K - 1);
      win_y <= out_row[clog2_min1(IMG_H)-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_rb_window_reader.sv
module tb_rb_window_reader;
  import rb_window_reader_pkg::*;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;
  localparam int NUM_RB = 4;
  localparam int RD_AW  = $clog2(NUM_RB * IMG_W);
  localparam int WIN_W  = K * K * DATA_W;
  localparam int CNT_W  = $clog2(NUM_RB + 1);
  localparam int WX     = IMG_W - K + 1;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 wr_row_done;
  logic                 rd_en;
  logic [RD_AW-1:0]     rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 win_valid;
  logic                 win_ready;
  logic [WIN_W-1:0]     win_data;
  logic                 rb_release;
  logic                 busy;
  logic                 complete;
  logic                 ovf_err;
`ifdef RB_WIN_COORD_EN
  logic [2:0]           win_x;
  logic [2:0]           win_y;
`endif
  state_t               dbg_state;
  logic [CNT_W-1:0]     dbg_rows_avail;

  rb_window_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .wr_row_done    (wr_row_done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .win_valid      (win_valid),
    .win_ready      (win_ready),
    .win_data       (win_data),
    .rb_release     (rb_release),
    .busy           (busy),
    .complete       (complete),
    .ovf_err        (ovf_err),
`ifdef RB_WIN_COORD_EN
    .win_x          (win_x),
    .win_y          (win_y),
`endif
    .dbg_state      (dbg_state),
    .dbg_rows_avail (dbg_rows_avail)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BRAM model ----------------
  logic [DATA_W-1:0] mem [NUM_RB*IMG_W];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  logic [WIN_W-1:0] exp_q[$];
  logic [RD_AW-1:0] rd_log[$];
  int nwin, rel_seen, rows_written, feed_limit, coin_seen;
  bit feed_en, coin_pending;
  logic [CNT_W-1:0] coin_avail;

  task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window whose top-left pixel is image (x0, oy); pixel value = y*8+x.
  function automatic logic [WIN_W-1:0] exp_win(input int oy, input int x0);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DATA_W +: DATA_W] = DATA_W'((oy + r) * IMG_W + x0 + c);
    return w;
  endfunction

  task automatic load_frame_exp();
    exp_q.delete();
    for (int oy = 0; oy < IMG_H - K + 1; oy++)
      for (int x = 0; x < WX; x++) exp_q.push_back(exp_win(oy, x));
  endtask

  // One clock: handshake/release/read bookkeeping, then drive the writer.
  task automatic tick();
    logic hs;
    logic [WIN_W-1:0] d;
`ifdef RB_WIN_COORD_EN
    logic [2:0] wx, wy;
    wx = win_x;
    wy = win_y;
`endif
    hs = win_valid && win_ready;
    d  = win_data;
    @(negedge clk);
    wr_row_done = 1'b0;
    start       = 1'b0;
    if (hs) begin
      if (exp_q.size() == 0) check_v("win_extra", 32'd1, 32'd0);
      else begin
        check_w("win_data", d, exp_q.pop_front());
`ifdef RB_WIN_COORD_EN
        check_v("win_x", 32'(wx), 32'(nwin % WX));
        check_v("win_y", 32'(wy), 32'(nwin / WX));
`endif
      end
      nwin++;
    end
    if (rb_release) rel_seen++;
    if (rd_en) rd_log.push_back(rd_addr);
    if (coin_pending) begin
      check_v("coincident_avail", 32'(dbg_rows_avail), 32'(coin_avail));
      coin_pending = 1'b0;
    end
    if (feed_en && rows_written < feed_limit && rows_written - rel_seen < NUM_RB) begin
      for (int x = 0; x < IMG_W; x++)
        mem[(rows_written % NUM_RB) * IMG_W + x] = DATA_W'(rows_written * IMG_W + x);
      wr_row_done = 1'b1;
      if (rb_release) begin
        coin_pending = 1'b1;
        coin_avail   = dbg_rows_avail;
        coin_seen++;
      end
      rows_written++;
    end
  endtask

  task automatic do_reset();
    feed_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rows_written = 0;
    rel_seen     = 0;
    nwin         = 0;
    coin_pending = 1'b0;
    coin_seen    = 0;
    exp_q.delete();
    rd_log.delete();
  endtask

  task automatic start_and_measure(output int lat);
    start = 1'b1;
    tick();
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (win_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_to_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (dbg_state == S_DONE) begin
        done = 1'b1;
        break;
      end
    end
    check_v(tag, 32'(done), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    bit seen;
    int nrd;
    int wrap_idx;
    logic [WIN_W-1:0] snap;

    rst = 1'b1; start = 1'b0; wr_row_done = 1'b0; win_ready = 1'b0;
    feed_en = 1'b0; feed_limit = 0; coin_avail = '0;
    for (int i = 0; i < NUM_RB * IMG_W; i++) mem[i] = '0;
    do_reset();

    // Reset state
    check_v("rst_rd_en", 32'(rd_en), 32'd0);
    check_v("rst_win_valid", 32'(win_valid), 32'd0);
    check_w("rst_win_data", win_data, '0);
    check_v("rst_release", 32'(rb_release), 32'd0);
    check_v("rst_busy", 32'(busy), 32'd0);
    check_v("rst_complete", 32'(complete), 32'd0);
    check_v("rst_ovf", 32'(ovf_err), 32'd0);
    check_v("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check_v("rst_rows_avail", 32'(dbg_rows_avail), 32'd0);

    // Overflow: fill the ring while idle, then one more row
    feed_en = 1'b1; feed_limit = 8;
    repeat (6) tick();
    feed_en = 1'b0;
    check_v("ovf_fill_avail", 32'(dbg_rows_avail), 32'd4);
    check_v("ovf_before", 32'(ovf_err), 32'd0);
    wr_row_done = 1'b1;
    tick();
    check_v("ovf_set", 32'(ovf_err), 32'd1);
    check_v("ovf_avail_held", 32'(dbg_rows_avail), 32'd4);
    repeat (3) tick();
    check_v("ovf_sticky", 32'(ovf_err), 32'd1);
    do_reset();
    check_v("ovf_cleared", 32'(ovf_err), 32'd0);

    // Happy path with back-pressure on window 2
    feed_en = 1'b1; feed_limit = 3;
    repeat (5) tick();
    check_v("happy_avail", 32'(dbg_rows_avail), 32'd3);
    load_frame_exp();
    win_ready = 1'b1;
    start_and_measure(lat);
    check_v("happy_latency", 32'(lat), 32'd14);
    check_w("happy_first_win", win_data, exp_win(0, 0));
    check_v("happy_busy", 32'(busy), 32'd1);
    tick();
    win_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (win_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_v("bp_win2_seen", 32'(seen), 32'd1);
    snap = win_data;
    check_w("bp_win2_data", snap, exp_win(0, 1));
    nrd = rd_log.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_v("bp_valid_held", 32'(win_valid), 32'd1);
      check_w("bp_data_held", win_data, snap);
    end
    check_v("bp_no_reads", 32'(rd_log.size()), 32'(nrd));
    win_ready = 1'b1;
    feed_limit = 8;
    run_to_done("happy_done");
    check_v("happy_nwin", 32'(nwin), 32'd36);
    check_v("happy_exp_empty", 32'(exp_q.size()), 32'd0);
    check_v("happy_releases", 32'(rel_seen), 32'd6);
    check_v("happy_complete", 32'(complete), 32'd1);
    check_v("happy_busy_low", 32'(busy), 32'd0);
    check_v("happy_ovf", 32'(ovf_err), 32'd0);
    check_v("happy_coincident_seen", 32'(coin_seen > 0), 32'd1);

    // Starvation and ring wrap
    do_reset();
    feed_en = 1'b1; feed_limit = 3;
    repeat (5) tick();
    load_frame_exp();
    win_ready = 1'b1;
    start = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (rel_seen >= 1) begin
        seen = 1'b1;
        break;
      end
    end
    check_v("starve_release", 32'(seen), 32'd1);
    repeat (5) tick();
    check_v("starve_nwin", 32'(nwin), 32'd6);
    check_v("starve_state", 32'(dbg_state), 32'(S_WAIT));
    check_v("starve_busy", 32'(busy), 32'd1);
    check_v("starve_valid", 32'(win_valid), 32'd0);
    check_v("starve_avail", 32'(dbg_rows_avail), 32'd2);
    rd_log.delete();
    feed_limit = 4;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rd_log.size() >= 3) break;
    end
    check_v("starve_rd_cnt", 32'(rd_log.size() >= 3), 32'd1);
    if (rd_log.size() >= 3) begin
      check_v("starve_rd0", 32'(rd_log[0]), 32'd8);
      check_v("starve_rd1", 32'(rd_log[1]), 32'd16);
      check_v("starve_rd2", 32'(rd_log[2]), 32'd24);
    end
    feed_limit = 8;
    run_to_done("wrap_done");
    wrap_idx = -1;
    for (int i = 0; i < rd_log.size(); i++) begin
      if (rd_log[i] < RD_AW'(IMG_W)) begin
        wrap_idx = i;
        break;
      end
    end
    check_v("wrap_seen", 32'(wrap_idx >= 0), 32'd1);
    if (wrap_idx >= 0) check_v("wrap_first_addr", 32'(rd_log[wrap_idx]), 32'd0);
    check_v("wrap_nwin", 32'(nwin), 32'd36);
    check_v("wrap_exp_empty", 32'(exp_q.size()), 32'd0);
    check_v("wrap_releases", 32'(rel_seen), 32'd6);

    // Reset in the middle of a frame
    do_reset();
    feed_en = 1'b1; feed_limit = 3;
    repeat (5) tick();
    load_frame_exp();
    win_ready = 1'b1;
    start = 1'b1;
    tick();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (nwin >= 2 && dbg_state == S_RD) begin
        seen = 1'b1;
        break;
      end
    end
    check_v("mid_reached_rd", 32'(seen), 32'd1);
    feed_en = 1'b0;
    rst = 1'b1;
    tick();
    check_v("mid_rd_en", 32'(rd_en), 32'd0);
    check_v("mid_win_valid", 32'(win_valid), 32'd0);
    check_w("mid_win_data", win_data, '0);
    check_v("mid_release", 32'(rb_release), 32'd0);
    check_v("mid_busy", 32'(busy), 32'd0);
    check_v("mid_complete", 32'(complete), 32'd0);
    check_v("mid_state", 32'(dbg_state), 32'(S_IDLE));
    check_v("mid_rows_avail", 32'(dbg_rows_avail), 32'd0);
    rst = 1'b0;
    rows_written = 0; rel_seen = 0; nwin = 0;
    exp_q.delete();
    feed_en = 1'b1; feed_limit = 3;
    repeat (5) tick();
    load_frame_exp();
    start_and_measure(lat);
    check_v("fresh_latency", 32'(lat), 32'd14);
    check_w("fresh_first_win", win_data, exp_win(0, 0));
    tick();
    check_v("fresh_nwin", 32'(nwin), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rb_window_reader.md
Name: rb_window_reader

Overview:
- Read-side controller for the BRAM row-buffer ring.
- Consumes row-committed pulses from the write-side control module.
- Reads K vertically adjacent row buffers column by column through BRAM port B and assembles a KxK pixel window.
- Presents each window to the downstream neighbourhood-image-processing (NIP) kernel over a valid/ready handshake.
- Releases the oldest row buffer to the writer after each output row completes.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 8, image width in pixels; also the depth of one row buffer
- IMG_H, 8, image height in rows
- K, 3, window size (KxK); must satisfy K <= IMG_W and K <= IMG_H
- NUM_RB, 4, number of row buffers in the BRAM ring; must satisfy NUM_RB >= K+1
- RD_AW, $clog2(NUM_RB*IMG_W), BRAM read address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame start pulse
- wr_row_done  in  1  one-cycle pulse from writer: a full row has been committed to the next ring slot
- rd_en  out  1  BRAM port-B read enable
- rd_addr  out  RD_AW  BRAM port-B address
- rd_data  in  DATA_W  BRAM read data, valid exactly 1 cycle after rd_en
- win_valid  out  1  window available
- win_ready  in  1  downstream accepts the window
- win_data  out  K*K*DATA_W  window; pixel (r,c) at [(r*K+c)*DATA_W +: DATA_W], r=0 is the top row, c=0 is the oldest (leftmost) column
- rb_release  out  1  one-cycle pulse: oldest row buffer freed
- busy  out  1  frame in progress
- complete  out  1  high while in S_DONE
- ovf_err  out  1  sticky: wr_row_done arrived while ring full

Behaviour:
- Reset (rst=1 at clk edge):
  - state=S_IDLE.
  - All outputs 0; win_data=0.
  - rows_avail=0, top_rb=0, col=0, out_row=0, ovf_err=0.
  - Reset mid-frame aborts immediately. No release pulse is issued.
- rows_avail counter, 0..NUM_RB:
  - +1 on wr_row_done, -1 on rb_release; both in the same cycle gives no change.
  - wr_row_done while rows_avail==NUM_RB (with no simultaneous release): count held, ovf_err set until rst.
  - Counts in every state, including IDLE and DONE.
- States:
  - S_IDLE: on start → S_WAIT. In the same cycle clear top_rb, col and out_row. win_data is not cleared.
  - S_WAIT: if rows_avail >= K → S_RD; otherwise stay.
  - S_RD: K cycles. In cycle r (r=0..K-1), rd_en=1 and rd_addr=((top_rb+r) mod NUM_RB)*IMG_W + col. Data for r is captured into column stage slot r on the following cycle. After r=K-1 → S_CAP.
  - S_CAP: 1 cycle. Capture the last datum and shift win_data one column left; the new column enters c=K-1.
    - If col < K-1: col++ → S_RD.
    - Otherwise → S_OUT.
  - S_OUT: win_valid=1; win_data is stable until the handshake.
    - On win_valid & win_ready with col < IMG_W-1: col++ → S_RD.
    - On handshake with col == IMG_W-1: pulse rb_release; top_rb=(top_rb+1) mod NUM_RB; col=0; out_row++.
      - If the new out_row == IMG_H-K+1 → S_DONE.
      - Otherwise → S_WAIT.
  - S_DONE: complete=1. On start → behaves as S_IDLE+start (→ S_WAIT). Otherwise hold.
- busy=1 in S_WAIT, S_RD, S_CAP and S_OUT.
- start is ignored while busy.
- Throughput: one column costs K+1 cycles; (IMG_W-K+1)*(IMG_H-K+1) windows per frame.
- Latency: with rows_avail>=K at start, the first win_valid rises at edge 2+K*(K+1) after the edge sampling start (14 for K=3).
- win_ready asserted while win_valid=0 has no effect.

Optional Feature:
- Macro: RB_WIN_COORD_EN.
- Defined: adds outputs win_x ($clog2(IMG_W) bits) and win_y ($clog2(IMG_H) bits).
  - win_x = col-(K-1) (left edge of window); win_y = out_row.
  - Registered and held with win_data; reset 0.
- Undefined: ports absent; no coordinate counters exist.

Decomposition:
- params.vh gains:
  - DATA_W, IMG_W, IMG_H, K, NUM_RB, RD_AW defaults.
  - State encodings S_IDLE=0, S_WAIT=1, S_RD=2, S_CAP=3, S_OUT=4, S_DONE=5 (3 bits).
- One sub-module: rb_window_shift. Holds K column stage registers and the KxK shift array, with capture/shift enables driven by the FSM.

Test Plan:
- Common setup: K=3, IMG_W=IMG_H=8, NUM_RB=4; BRAM model holds pixel = (y*8+x) mod 256, with row y in slot y mod 4.
- Happy path: pulse wr_row_done 3×, then start, win_ready=1 → first win_valid at edge 14 after start, win_data = {0,1,2 / 8,9,10 / 16,17,18}. Continue feeding rows → exactly 36 windows, then complete=1 and 6 rb_release pulses.
- Back-pressure: win_ready=0 for 10 cycles on window 2 → win_valid held, win_data unchanged, no rd_en toggling. Release → window 3 = {2,3,4 / 10,11,12 / 18,19,20}.
- Starvation/wrap: supply only 3 rows → after 6 windows, rb_release and stall in S_WAIT. Then pulse row 4 → next reads address slots 1,2,3 and later wrap to slot 0 (rd_addr 0..7).
- Simultaneous events: wr_row_done coincident with rb_release keeps rows_avail constant. A 5th row while rows_avail==4 sets ovf_err.
- Reset mid-frame: rst during S_RD → next cycle all outputs 0, state S_IDLE. A fresh frame then reproduces the happy-path first window.
- With RB_WIN_COORD_EN: win_x/win_y sequence is (0,0),(1,0)..(5,0),(0,1)…(5,5).
